// File: rtl/sha3_pkg.sv
// Shared constants and FSM state encoding for the SHA3 absorb controller.
package sha3_pkg;

    localparam int unsigned LANE_W   = 64;
    localparam int unsigned STATE_W  = 1600;
    localparam int unsigned DIGEST_W = 256;

    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef logic [2:0] sha3_state_t;

    localparam sha3_state_t IDLE    = 3'd0;
    localparam sha3_state_t ABSORB  = 3'd1;
    localparam sha3_state_t PERMUTE = 3'd2;
    localparam sha3_state_t PAD     = 3'd3;
    localparam sha3_state_t SQUEEZE = 3'd4;
    localparam sha3_state_t ERROR   = 3'd5;

endpackage

// File: rtl/sha3_pad_lane.sv
// Combinational lane padder: masks bytes past the valid count and applies the
// 0x06 domain byte and, in the rate's final lane, the 0x80 closing byte.
module sha3_pad_lane
    import sha3_pkg::*;
(
    input  logic [LANE_W-1:0] data,
    input  logic [3:0]        bytes,
    input  logic              last,
    input  logic              final_lane,
    output logic [LANE_W-1:0] padded
);

    logic [3:0] nbytes;

    always_comb begin
        nbytes = !last ? 4'd8 : ((bytes > 4'd8) ? 4'd8 : bytes);
        padded = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                padded[8*i +: 8] = data[8*i +: 8];
            end else if (last && (4'(i) == nbytes)) begin
                padded[8*i +: 8] = PAD_DOMAIN;
            end
        end
        // A full final word leaves no room; the caller schedules a padding-only block.
        if (last && final_lane && (nbytes < 4'd8)) begin
            padded[LANE_W-1 -: 8] = padded[LANE_W-1 -: 8] ^ PAD_FINAL;
        end
    end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// SHA3 absorb/pad/squeeze sequencer around an external Keccak-f[1600] core.
// Optional permutation watchdog: define SHA3_PERM_WATCHDOG_EN.
module sha3_absorb_ctrl
    import sha3_pkg::*;
#(
    parameter int unsigned RATE  = 1088,
    parameter int unsigned TMO_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic [LANE_W-1:0]   msg_data,
    input  logic                msg_last,
    input  logic [3:0]          msg_bytes,
    output logic                perm_start,
    output logic [STATE_W-1:0]  perm_a,
    input  logic [STATE_W-1:0]  perm_x,
    input  logic                perm_done,
    output logic                digest_valid,
    input  logic                digest_ready,
    output logic [DIGEST_W-1:0] digest,
    output logic                busy,
    output logic                err
);

    localparam int unsigned LANES = RATE / LANE_W;
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [STATE_W-1:0] PAD_BLOCK =
        STATE_W'(PAD_DOMAIN) ^ (STATE_W'(PAD_FINAL) << (RATE - 8));

    if ((RATE == 0) || ((RATE % LANE_W) != 0) || (RATE > STATE_W) || (TMO_W < 2))
    begin : g_param_check
        $error("sha3_absorb_ctrl: RATE must be a non-zero multiple of 64 up to 1600");
    end

    sha3_state_t         fsm_q, fsm_d, fsm_base;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic                last_q, last_d;
    logic                pad_pend_q, pad_pend_d;
    logic                start_q, start_d;
    logic                live_q;
    logic                final_lane, accept, in_perm, wdt_trip;
    logic [LANE_W-1:0]   padded;

    assign final_lane = (lane_q == LW'(LANES - 1));
    // live_q keeps msg_ready low until the first clock after reset release.
    assign msg_ready  = live_q && ((fsm_q == IDLE) || (fsm_q == ABSORB));
    assign accept     = msg_valid && msg_ready;
    assign in_perm    = (fsm_q == PERMUTE) || (fsm_q == PAD);

    sha3_pad_lane u_pad_lane (
        .data       (msg_data),
        .bytes      (msg_bytes),
        .last       (msg_last),
        .final_lane (final_lane),
        .padded     (padded)
    );

    always_comb begin
        fsm_base   = fsm_q;
        state_d    = state_q;
        lane_d     = lane_q;
        last_d     = last_q;
        pad_pend_d = pad_pend_q;
        case (fsm_q)
            IDLE, ABSORB: begin
                if (fsm_q == IDLE) begin
                    state_d    = '0;
                    lane_d     = '0;
                    last_d     = 1'b0;
                    pad_pend_d = 1'b0;
                end
                if (accept) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (lane_q == LW'(k)) begin
                            state_d[k*LANE_W +: LANE_W] = state_d[k*LANE_W +: LANE_W] ^ padded;
                        end
                    end
                    if (msg_last && !final_lane) begin
                        state_d[RATE-1 -: 8] = state_d[RATE-1 -: 8] ^ PAD_FINAL;
                    end
                    if (msg_last || final_lane) begin
                        fsm_base   = PERMUTE;
                        lane_d     = '0;
                        last_d     = msg_last;
                        pad_pend_d = msg_last && final_lane && (msg_bytes >= 4'd8);
                    end else begin
                        fsm_base = ABSORB;
                        lane_d   = lane_q + 1'b1;
                    end
                end
            end
            PERMUTE: begin
                if (perm_done) begin
                    state_d    = perm_x;
                    pad_pend_d = 1'b0;
                    if (pad_pend_q) begin
                        fsm_base = PAD;
                    end else if (last_q) begin
                        fsm_base = SQUEEZE;
                    end else begin
                        fsm_base = ABSORB;
                    end
                end
            end
            PAD: begin
                if (perm_done) begin
                    state_d  = perm_x;
                    fsm_base = SQUEEZE;
                end
            end
            SQUEEZE: begin
                if (digest_ready) begin
                    fsm_base = IDLE;
                end
            end
`ifdef SHA3_PERM_WATCHDOG_EN
            ERROR: fsm_base = ERROR;
`endif
            default: fsm_base = IDLE;
        endcase
        fsm_d   = wdt_trip ? ERROR : fsm_base;
        start_d = ((fsm_d == PERMUTE) || (fsm_d == PAD)) && (fsm_d != fsm_q);
    end

`ifdef SHA3_PERM_WATCHDOG_EN
    logic [TMO_W-1:0] wdt_q;

    // Trip on the cycle the counter would reach all-ones without a completion.
    assign wdt_trip = in_perm && !perm_done && (wdt_q == ~TMO_W'(1));
    assign err      = (fsm_q == ERROR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_q <= '0;
        end else if (start_d) begin
            wdt_q <= '0;
        end else if (in_perm) begin
            wdt_q <= wdt_q + 1'b1;
        end
    end
`else
    assign wdt_trip = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            lane_q     <= '0;
            last_q     <= 1'b0;
            pad_pend_q <= 1'b0;
            start_q    <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            lane_q     <= lane_d;
            last_q     <= last_d;
            pad_pend_q <= pad_pend_d;
            start_q    <= start_d;
            live_q     <= 1'b1;
        end
    end

    assign perm_start   = start_q;
    assign perm_a       = (fsm_q == PAD) ? (state_q ^ PAD_BLOCK) : state_q;
    assign busy         = (fsm_q != IDLE);
    assign digest_valid = (fsm_q == SQUEEZE);

    always_comb begin
        digest = '0;
        if (fsm_q == SQUEEZE) begin
            for (int i = 0; i < DIGEST_W / 8; i++) begin
                digest[DIGEST_W-1-8*i -: 8] = state_q[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/sha3_absorb_ctrl.md
SHA3_ABSORB_CTRL -- requirements
Module: sha3_absorb_ctrl

Interface
REQ-001 SHALL have parameter RATE, default 1088, meaning absorb rate in bits; it must be a multiple of 64.
REQ-002 SHALL have parameter TMO_W, default 8, meaning watchdog counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports msg_valid (input, 1), msg_ready (output, 1), msg_data (input, 64) and msg_last (input, 1): the message word stream.
REQ-006 SHALL have port msg_bytes, input, 4 bits: valid byte count (0..8) of the word; honoured only when msg_last=1, otherwise treated as 8.
REQ-007 SHALL have port perm_start, output, 1 bit: one-cycle pulse that launches the Keccak-f[1600] core.
REQ-008 SHALL have ports perm_a (output, 1600) and perm_x (input, 1600): the core's input and output state.
REQ-009 SHALL have port perm_done, input, 1 bit: one-cycle completion pulse; perm_x is valid in that cycle.
REQ-010 SHALL have ports digest_valid (output, 1), digest_ready (input, 1) and digest (output, 256).
REQ-011 SHALL have ports busy (output, 1) and err (output, 1).

Function
REQ-012 SHALL use FSM states IDLE, ABSORB, PERMUTE, PAD, SQUEEZE and ERROR.
REQ-013 SHALL assert msg_ready only in IDLE and ABSORB; a word is accepted when msg_valid and msg_ready are both 1.
- Word k of a block XORs into lane k, state bits [64k+63:64k], little-endian bytes.
REQ-014 IDLE SHALL clear the 1600-bit state register and lane counter; the first accepted word moves the FSM to ABSORB.
REQ-015 After lane RATE/64-1 is accepted, the block SHALL close and the FSM SHALL enter PERMUTE.
- msg_ready=0 until perm_done.
REQ-016 A block containing msg_last SHALL be padded before permutation.
- Pad byte 0x06 is XORed at byte offset (lane*8+msg_bytes); 0x80 is XORed at byte RATE/8-1; both apply to the same byte if coincident.
REQ-017 If msg_last arrives in the final lane with msg_bytes=8, the current block SHALL be permuted unpadded, then the FSM SHALL enter PAD, which permutes a block holding only the padding.
REQ-018 msg_last with msg_bytes=0 SHALL be legal (including empty message) and pad at that word's byte 0.
REQ-019 perm_start SHALL pulse exactly one cycle after entry to PERMUTE/PAD.
- perm_a = state XOR padded block, held stable until perm_done.
- State register loads perm_x on perm_done.
REQ-020 After the last permutation the FSM SHALL enter SQUEEZE.
- digest_valid=1; digest[255:248] = state byte 0 ... digest[7:0] = state byte 31.
- digest_valid and digest are held until digest_ready=1, then the FSM returns to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 perm_done outside PERMUTE/PAD SHALL be ignored.
REQ-023 msg_valid=0 mid-block SHALL stall the lane counter without side effect.

Reset
REQ-024 On rst=0 SHALL, asynchronously, enter IDLE.
- Cleared: state register, lane counter, watchdog.
- Outputs: msg_ready=0, perm_start=0, digest_valid=0, digest=0, busy=0, err=0; msg_ready rises the cycle after release.
REQ-025 Reset during PERMUTE SHALL abandon the operation; a perm_done arriving after release SHALL be ignored.

Configuration
REQ-026 With macro SHA3_PERM_WATCHDOG_EN defined, a TMO_W-bit counter SHALL start at perm_start and SHALL run during PERMUTE/PAD.
- Saturation before perm_done: enter ERROR with err=1, msg_ready=0.
- ERROR exits only by reset.
REQ-027 Without SHA3_PERM_WATCHDOG_EN, the counter and ERROR SHALL not be built, err SHALL be tied 0, and the wait for perm_done SHALL be unbounded.

Structure
REQ-028 Package sha3_pkg SHALL hold the FSM state enum, constants LANE_W=64, STATE_W=1600, DIGEST_W=256, PAD_DOMAIN=8'h06, PAD_FINAL=8'h80.
REQ-029 Sub-module sha3_pad_lane (combinational: lane data, msg_bytes, last, final-lane flags -> padded 64-bit lane) SHALL be the only sub-module; the Keccak core stays external.

Verification
REQ-030 Empty message (one word, msg_last=1, msg_bytes=0), core model present -> single permutation; digest = a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a.
REQ-031 "abc" (msg_data=64'h636261, msg_bytes=3, msg_last) -> digest = 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
REQ-032 136-byte message (17 full words, last msg_bytes=8) -> exactly two perm_start pulses; second block = 0x06 at byte 0, 0x80 at byte 135.
REQ-033 135-byte message -> one permutation; byte 135 of the block = 0x86.
REQ-034 digest_ready held 0 for 10 cycles -> digest_valid and digest stable, msg_ready=0; on ready=1, IDLE next cycle.
REQ-035 rst=0 mid-PERMUTE, then a late perm_done -> all outputs reset, no state load; with SHA3_PERM_WATCHDOG_EN and perm_done withheld, err=1 after 2^TMO_W-1 cycles.
